// File: rtl/gpu_cmd_pkg.sv
// Shared GPU command definitions: opcodes, CMD bit indices, wait masks and opcode decode.
package gpu_cmd_pkg;

    localparam logic [7:0] OP_SWAP        = 8'h01;
    localparam logic [7:0] OP_CLEAN       = 8'h02;
    localparam logic [7:0] OP_LOAD_VERTEX = 8'h03;
    localparam logic [7:0] OP_LOAD_EDGE   = 8'h05;
    localparam logic [7:0] OP_DRAW_TRI    = 8'h06;
    localparam logic [7:0] OP_STATUS      = 8'h07;

    localparam logic [2:0] IDX_SWAP        = 3'd0;
    localparam logic [2:0] IDX_CLEAN       = 3'd1;
    localparam logic [2:0] IDX_LOAD_VERTEX = 3'd2;
    localparam logic [2:0] IDX_LOAD_EDGE   = 3'd4;
    localparam logic [2:0] IDX_DRAW_TRI    = 3'd5;
    localparam logic [2:0] IDX_STATUS      = 3'd7;

    localparam logic [7:0] MASK_SWAP        = 8'h37;
    localparam logic [7:0] MASK_CLEAN       = 8'h22;
    localparam logic [7:0] MASK_LOAD_VERTEX = 8'h24;
    localparam logic [7:0] MASK_LOAD_EDGE   = 8'h30;
    localparam logic [7:0] MASK_DRAW_TRI    = 8'h36;
    localparam logic [7:0] MASK_STATUS      = 8'h80;

    typedef struct packed {
        logic       valid;
        logic [2:0] idx;
    } op_dec_t;

    typedef enum logic {S_IDLE = 1'b0, S_HOLD = 1'b1} sched_state_t;

    function automatic op_dec_t opcode_to_idx(input logic [7:0] op);
        op_dec_t d;
        d = '{valid: 1'b0, idx: 3'd0};
        case (op)
            OP_SWAP:        d = '{valid: 1'b1, idx: IDX_SWAP};
            OP_CLEAN:       d = '{valid: 1'b1, idx: IDX_CLEAN};
            OP_LOAD_VERTEX: d = '{valid: 1'b1, idx: IDX_LOAD_VERTEX};
            OP_LOAD_EDGE:   d = '{valid: 1'b1, idx: IDX_LOAD_EDGE};
            OP_DRAW_TRI:    d = '{valid: 1'b1, idx: IDX_DRAW_TRI};
            OP_STATUS:      d = '{valid: 1'b1, idx: IDX_STATUS};
            default:        d = '{valid: 1'b0, idx: 3'd0};
        endcase
        return d;
    endfunction

    // Unused indices wait on every unit so a corrupted entry can never issue early.
    function automatic logic [7:0] idx_to_mask(input logic [2:0] idx);
        case (idx)
            IDX_SWAP:        return MASK_SWAP;
            IDX_CLEAN:       return MASK_CLEAN;
            IDX_LOAD_VERTEX: return MASK_LOAD_VERTEX;
            IDX_LOAD_EDGE:   return MASK_LOAD_EDGE;
            IDX_DRAW_TRI:    return MASK_DRAW_TRI;
            IDX_STATUS:      return MASK_STATUS;
            default:         return 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous FIFO with registered full/empty/level; overflowing pushes and empty pops are ignored.
module cmd_fifo #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    level_next;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_comb begin
        level_next = level;
        case ({push_ok, pop_ok})
            2'b10:   level_next = level + LW'(1);
            2'b01:   level_next = level - LW'(1);
            default: level_next = level;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            level <= level_next;
            full  <= (level_next == LW'(DEPTH));
            empty <= (level_next == LW'(0));
        end
    end

endmodule

// File: rtl/cmd_scheduler.sv
// In-order GPU command scheduler: queues valid opcodes and issues each once its wait mask is clear.
module cmd_scheduler
    import gpu_cmd_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                     CLK,
    input  logic                     rst,
    input  logic                     packet_ready,
    input  logic [7:0]               opcode,
    input  logic [7:0]               BUSY,
    output logic [7:0]               CMD,
    output logic                     FULL,
    output logic                     EMPTY,
    output logic [$clog2(DEPTH):0]   LEVEL,
    output logic                     DROP,
    output logic                     IDLE
);
    localparam int CW = $clog2(HOLD_CYCLES + 1);

    sched_state_t state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [7:0]    cmd_next;
    logic [2:0]    head;
    logic          pop;
    logic          push;
    logic          drop_next;
    op_dec_t       dec;

    assign dec       = opcode_to_idx(opcode);
    assign push      = packet_ready && dec.valid && !FULL;
    assign drop_next = packet_ready && (!dec.valid || FULL);
    assign IDLE      = EMPTY && (state == S_IDLE) && (BUSY == 8'h00);

    cmd_fifo #(.WIDTH(3), .DEPTH(DEPTH)) u_fifo (
        .clk       (CLK),
        .rst       (rst),
        .push      (push),
        .push_data (dec.idx),
        .pop       (pop),
        .head      (head),
        .full      (FULL),
        .empty     (EMPTY),
        .level     (LEVEL)
    );

    // The hold window leaves the started unit time to raise BUSY before the next mask check.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        cmd_next   = 8'h00;
        pop        = 1'b0;
        case (state)
            S_IDLE: begin
                if (!EMPTY && ((BUSY & idx_to_mask(head)) == 8'h00)) begin
                    cmd_next   = 8'h01 << head;
                    pop        = 1'b1;
                    cnt_next   = CW'(HOLD_CYCLES);
                    state_next = S_HOLD;
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_HOLD: begin
                if (cnt <= CW'(1)) begin
                    cnt_next   = CW'(0);
                    state_next = S_IDLE;
                end else begin
                    cnt_next   = cnt - CW'(1);
                end
            end
            default: begin
                cnt_next   = CW'(0);
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            CMD   <= 8'h00;
            DROP  <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            CMD   <= cmd_next;
            DROP  <= drop_next;
        end
    end

endmodule

// File: tb/tb_cmd_scheduler.sv
// Scoreboard bench for cmd_scheduler: a queue-level reference model predicts issues and drops.
module tb_cmd_scheduler;
    localparam int DEPTH = 8;
    localparam int HOLD  = 2;

    logic       CLK = 1'b0;
    logic       rst;
    logic       packet_ready;
    logic [7:0] opcode;
    logic [7:0] BUSY;
    logic [7:0] CMD;
    logic       FULL, EMPTY, DROP, IDLE;
    logic [3:0] LEVEL;

    typedef struct {
        int         cyc;
        logic [7:0] val;
    } ev_t;

    ev_t exp_cmd[$];
    int  exp_drop[$];
    int  mq[$];
    int  cyc       = 0;
    int  last      = -100;
    int  exp_level = 0;
    int  vectors   = 0;
    int  errs      = 0;

    cmd_scheduler #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD)) dut (
        .CLK(CLK), .rst(rst), .packet_ready(packet_ready), .opcode(opcode),
        .BUSY(BUSY), .CMD(CMD), .FULL(FULL), .EMPTY(EMPTY), .LEVEL(LEVEL),
        .DROP(DROP), .IDLE(IDLE)
    );

    always #5 CLK = ~CLK;

    function automatic int ref_index(input logic [7:0] op);
        case (op)
            8'h01: return 0;
            8'h02: return 1;
            8'h03: return 2;
            8'h05: return 4;
            8'h06: return 5;
            8'h07: return 7;
            default: return -1;
        endcase
    endfunction

    function automatic logic [7:0] ref_mask(input int i);
        case (i)
            0: return 8'b0011_0111;
            1: return 8'b0010_0010;
            2: return 8'b0010_0100;
            4: return 8'b0011_0000;
            5: return 8'b0011_0110;
            default: return 8'b1000_0000;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: an issue needs a non-empty queue, HOLD+1 cycles since the last issue, and a clear mask.
    task automatic model_step();
        int pre;
        cyc++;
        if (rst) begin
            mq.delete();
            last = -100;
        end else begin
            pre = mq.size();
            if (pre > 0 && cyc >= last + HOLD + 1 && (BUSY & ref_mask(mq[0])) == 8'h00) begin
                logic [7:0] one;
                one = 8'h01;
                exp_cmd.push_back('{cyc: cyc, val: one << mq[0]});
                last = cyc;
                void'(mq.pop_front());
            end
            if (packet_ready) begin
                if (ref_index(opcode) >= 0 && pre < DEPTH) mq.push_back(ref_index(opcode));
                else exp_drop.push_back(cyc);
            end
        end
        exp_level = mq.size();
    endtask

    task automatic drv(input logic r, input logic pr, input logic [7:0] op, input logic [7:0] b);
        rst = r; packet_ready = pr; opcode = op; BUSY = b;
        @(posedge CLK);
        model_step();
        #2;
    endtask

    task automatic idle_cycles(input int n, input logic [7:0] b);
        for (int i = 0; i < n; i++) drv(1'b0, 1'b0, 8'h00, b);
    endtask

    // Monitor: every cycle compares status outputs and pops the expected CMD/DROP event for this cycle.
    always @(negedge CLK) begin
        if (cyc > 0) begin
            chk("level", 32'(LEVEL), 32'(exp_level));
            chk("full", 32'(FULL), 32'(exp_level == DEPTH));
            chk("empty", 32'(EMPTY), 32'(exp_level == 0));
            chk("idle", 32'(IDLE), 32'(exp_level == 0 && cyc >= last + HOLD && BUSY == 8'h00));
            if (exp_cmd.size() > 0 && exp_cmd[0].cyc == cyc) begin
                chk("cmd", 32'(CMD), 32'(exp_cmd[0].val));
                void'(exp_cmd.pop_front());
            end else begin
                chk("cmd_quiet", 32'(CMD), 32'h0);
            end
            if (exp_drop.size() > 0 && exp_drop[0] == cyc) begin
                chk("drop", 32'(DROP), 32'h1);
                void'(exp_drop.pop_front());
            end else begin
                chk("drop_quiet", 32'(DROP), 32'h0);
            end
        end
    end

    initial begin
        logic [7:0] ops [6];
        logic [7:0] op, b;
        ops[0] = 8'h01; ops[1] = 8'h02; ops[2] = 8'h03;
        ops[3] = 8'h05; ops[4] = 8'h06; ops[5] = 8'h07;

        drv(1'b1, 1'b1, 8'h02, 8'h00);
        drv(1'b1, 1'b0, 8'h00, 8'h00);

        drv(1'b0, 1'b1, 8'h02, 8'h00);
        idle_cycles(5, 8'h00);

        drv(1'b0, 1'b1, 8'h06, 8'h04);
        idle_cycles(10, 8'h04);
        idle_cycles(5, 8'h00);

        drv(1'b0, 1'b1, 8'h03, 8'h00);
        drv(1'b0, 1'b1, 8'h05, 8'h00);
        drv(1'b0, 1'b1, 8'h06, 8'h00);
        idle_cycles(12, 8'h00);

        for (int i = 0; i < 9; i++) drv(1'b0, 1'b1, 8'h03, 8'h20);
        drv(1'b0, 1'b1, 8'h04, 8'h20);
        drv(1'b0, 1'b1, 8'hFF, 8'h20);
        idle_cycles(3, 8'h20);
        idle_cycles(40, 8'h00);

        drv(1'b0, 1'b1, 8'h01, 8'h80);
        idle_cycles(5, 8'h80);
        drv(1'b0, 1'b1, 8'h01, 8'h02);
        idle_cycles(6, 8'h02);
        idle_cycles(5, 8'h00);

        for (int i = 0; i < 8; i++) drv(1'b0, 1'b1, 8'h07, 8'h00);
        drv(1'b1, 1'b1, 8'h07, 8'h00);
        idle_cycles(10, 8'h00);

        for (int i = 0; i < 700; i++) begin
            op = ($urandom_range(0, 3) == 0) ? 8'($urandom) : ops[$urandom_range(0, 5)];
            b  = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom & $urandom & $urandom);
            drv(($urandom_range(0, 199) == 0), ($urandom_range(0, 1) == 1), op, b);
        end
        idle_cycles(60, 8'h00);

        chk("cmd_backlog", 32'(exp_cmd.size()), 32'h0);
        chk("drop_backlog", 32'(exp_drop.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/cmd_scheduler.md
# cmd_scheduler

Buffers command packets from the host packet interface and issues them to the GPU functional units in order, one at a time. It replaces drop-on-busy dispatch: a command whose target or conflicting units are busy waits in a queue instead of being lost. It sits between the packet receiver (`packet_ready`/`opcode`) and the unit start strobes (`CMD[7:0]`), consuming the units' `BUSY[7:0]` flags.

## Interface
- `DEPTH`, 8: queue entries; power of two, at least 2.
- `HOLD_CYCLES`, 2: cycles after an issue before the next issue is evaluated, giving the started unit time to raise `BUSY`; at least 1.
- `CLK`  in  1  system clock.
- `rst`  in  1  reset; one clock; reset is synchronous and active-high.
- `packet_ready`  in  1  one-cycle strobe; `opcode` valid.
- `opcode`  in  8  command opcode.
- `BUSY`  in  8  per-unit busy flags, same bit indices as `CMD`.
- `CMD`  out  8  one-hot start pulse, at most one bit high, one cycle wide.
- `FULL`  out  1  queue holds `DEPTH` entries.
- `EMPTY`  out  1  queue holds 0 entries.
- `LEVEL`  out  $clog2(DEPTH)+1  queue occupancy.
- `DROP`  out  1  one-cycle pulse: packet rejected (invalid opcode or queue full).
- `IDLE`  out  1  queue empty, FSM in S_IDLE, `BUSY == 0`.

## Operation
- Opcode to `CMD` index: 0x01 SWAP→0, 0x02 CLEAN→1, 0x03 LOAD_VERTEX→2, 0x05 LOAD_EDGE→4, 0x06 DRAW_TRI→5, 0x07 STATUS→7. All other opcodes, including 0x04, are invalid.
- Enqueue: `packet_ready` with a valid opcode and `!FULL` → 3-bit index pushed. Invalid opcode, or `FULL`, → nothing pushed, `DROP` pulses. A push and a pop in the same cycle leave `LEVEL` unchanged. A push while `FULL` with a simultaneous pop is still dropped.
- Wait masks: the head entry may issue only when `(BUSY & MASK) == 0`.
  - SWAP: bits 0,1,2,4,5. This is the frame fence: all rendering must finish.
  - CLEAN: bits 1,5.
  - LOAD_VERTEX: bits 2,5.
  - LOAD_EDGE: bits 4,5.
  - DRAW_TRI: bits 1,2,4,5.
  - STATUS: bit 7.
- Strict in-order issue. A blocked head blocks every later entry (no bypass).
- FSM:
  - S_IDLE: if the queue is non-empty and the head's mask is clear → register `CMD[idx]=1`, pop, load hold counter with `HOLD_CYCLES`, go to S_HOLD. Otherwise stay.
  - S_HOLD: `CMD=0`; decrement the counter; when it reaches 1, go to S_IDLE.
- Reset (including mid-hold or mid-issue): queue flushed, state S_IDLE, counter 0. From the cycle after reset: `CMD=0`, `DROP=0`, `FULL=0`, `EMPTY=1`, `LEVEL=0`. `IDLE` follows `BUSY`. A `packet_ready` in a reset cycle is ignored and does not raise `DROP`.

## Timing
- All outputs are registered except `IDLE`, which is combinational from registered state and `BUSY`.
- Minimum latency: `packet_ready` sampled at edge k with an empty queue, S_IDLE, and mask clear → `CMD` high from edge k+1 to k+2.
- Back-to-back issue spacing is at least `HOLD_CYCLES`+1 cycles. With the default, the next `CMD` comes no earlier than 3 cycles after the previous one.
- `BUSY` is sampled at the edge that would register `CMD`. If `BUSY` clears at edge m, the issue occurs at edge m+1.
- `DROP` is high in the cycle after the rejected `packet_ready`.

## Structure
- Shared package `gpu_cmd_pkg`:
  - opcode constants;
  - `CMD` bit indices;
  - wait-mask constants;
  - function `opcode_to_idx` (returns valid flag + index).
  - `cmd_decoder` is later migrated onto this package.
- Sub-module `cmd_fifo`: synchronous FIFO, parameterised width/depth, with push/pop/full/empty/level. Pop-on-empty and push-on-full are ignored internally.
- Top level: opcode validation, hold counter, 2-state FSM, mask check.

## Test plan
- Reset, then 0x02 with `BUSY=0` → `CMD=8'h02` one cycle, one edge after acceptance; `LEVEL` returns to 0; `IDLE=1` after `BUSY` stays 0.
- 0x06 with `BUSY=8'h04` held 10 cycles → no `CMD`. Clear `BUSY` at edge m → `CMD=8'h20` at edge m+1.
- Burst 0x03, 0x05, 0x06 with `BUSY=0` → `CMD` 0x04, 0x10, 0x20 in order, each spaced 3 cycles.
- `BUSY=8'h20` fixed; push 9 × 0x03 → `LEVEL=8`, `FULL=1`, ninth gives `DROP`. Opcode 0x04 or 0xFF → `DROP`, `LEVEL` unchanged.
- 0x01 with `BUSY=8'h80` → `CMD=8'h01` immediately, since bit 7 is not in the SWAP mask. 0x01 with `BUSY=8'h02` → held until bit 1 clears.
- Assert `rst` in S_HOLD with `LEVEL=5` → next cycle `LEVEL=0`, `EMPTY=1`, `CMD=0`; no further `CMD` without new packets.
